// File: rtl/smpl_capture_multi_pkg.sv
// Shared state encoding and index-width helpers for the multi-channel sample capture block.
package smpl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_ARM     = ST_ARM,
        S_CAPTURE = ST_CAPTURE,
        S_DRAIN   = ST_DRAIN
    } smpl_state_e;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_CHW  = idx_w(2);
    localparam int DEF_IDXW = idx_w(64);

endpackage

// File: rtl/smpl_capture_multi_if.sv
// Control, sample-stream and output-stream signals of smpl_capture_multi.
interface smpl_capture_multi_if
    import smpl_pkg::*;
#(
    parameter int CH   = 2,
    parameter int SN   = 10,
    parameter int SIZE = 64,
    parameter int DECW = 8
);
    localparam int CHW  = idx_w(CH);
    localparam int IDXW = idx_w(SIZE);

    logic               start;
    logic               busy;
    logic               done;
    logic [DECW-1:0]    decim;
    logic               trig_en;
    logic [CHW-1:0]     trig_ch;
    logic [SN-1:0]      trig_level;
    logic               smpl_valid;
    logic               smpl_req;
    logic [CH*SN-1:0]   smpl;
    logic               out_valid;
    logic               out_ready;
    logic [SN-1:0]      out_data;
    logic [CHW-1:0]     out_ch;
    logic [IDXW-1:0]    out_idx;

    modport master (
        output start, decim, trig_en, trig_ch, trig_level, smpl_valid, smpl, out_ready,
        input  busy, done, smpl_req, out_valid, out_data, out_ch, out_idx
    );

    modport slave (
        input  start, decim, trig_en, trig_ch, trig_level, smpl_valid, smpl, out_ready,
        output busy, done, smpl_req, out_valid, out_data, out_ch, out_idx
    );

endinterface

// File: rtl/smpl_capture_multi_buf_ram.sv
// Simple dual-port frame buffer: one write port, one read port with registered output.
module smpl_buf_ram #(
    parameter int W     = 20,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clkSmpl,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clkSmpl) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/smpl_capture_multi.sv
// Triggered, decimating multi-channel capture into a frame buffer, then channel-major drain.
// Build option SMPL_PEAK_DETECT_EN: store each window's unsigned per-channel peak instead of its first sample.
module smpl_capture_multi
    import smpl_pkg::*;
#(
    parameter int CH   = 2,
    parameter int SN   = 10,
    parameter int SIZE = 64,
    parameter int DECW = 8
) (
    input  logic                clkSmpl,
    input  logic                n_reset,
    smpl_capture_multi_if.slave bus
);
    localparam int CHW  = idx_w(CH);
    localparam int IDXW = idx_w(SIZE);
    localparam int BW   = CH * SN;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(SIZE - 1);
    localparam logic [CHW-1:0]  CH_LAST  = CHW'(CH - 1);

    logic [1:0]      state;
    logic            busy_r, done_r;
    logic [DECW-1:0] decim_r, dec_cnt;
    logic            trig_en_r;
    logic [CHW-1:0]  trig_ch_r;
    logic [SN-1:0]   trig_lvl_r;
    logic [SN-1:0]   prev_smp;
    logic            prev_vld;
    logic [IDXW-1:0] wr_idx;
    logic            out_valid_r;
    logic [CHW-1:0]  out_ch_r;
    logic [IDXW-1:0] out_idx_r;

    logic            acc, trig_hit, take, win_last, wr_en, rd_last;
    logic [SN-1:0]   trig_smp, out_sel;
    logic [BW-1:0]   win_r, win_next, rd_word;
    logic [IDXW-1:0] rd_addr;

    assign bus.smpl_req  = (state == ST_ARM) || (state == ST_CAPTURE);
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_ch    = out_ch_r;
    assign bus.out_idx   = out_idx_r;

    assign acc = bus.smpl_valid && bus.smpl_req;

    always_comb begin
        trig_smp = '0;
        for (int c = 0; c < CH; c++)
            if (trig_ch_r == CHW'(c))
                trig_smp = bus.smpl[c*SN +: SN];
    end

    // The crossing sample itself is point 0, so it enters the window logic in the same cycle.
    assign trig_hit = acc && (state == ST_ARM) && trig_en_r && prev_vld &&
                      (prev_smp < trig_lvl_r) && (trig_smp >= trig_lvl_r);
    assign take     = acc && ((state == ST_CAPTURE) || trig_hit);
    assign win_last = (dec_cnt == decim_r);
    assign wr_en    = take && win_last;

`ifdef SMPL_PEAK_DETECT_EN
    function automatic logic [SN-1:0] umax(input logic [SN-1:0] a, input logic [SN-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        win_next = bus.smpl;
        if (dec_cnt != '0)
            for (int c = 0; c < CH; c++)
                win_next[c*SN +: SN] = umax(bus.smpl[c*SN +: SN], win_r[c*SN +: SN]);
    end
`else
    assign win_next = (dec_cnt == '0) ? bus.smpl : win_r;
`endif

    always_ff @(posedge clkSmpl) begin
        if (take)
            win_r <= win_next;
    end

    always_ff @(posedge clkSmpl or negedge n_reset) begin
        if (!n_reset) begin
            state       <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            decim_r     <= '0;
            dec_cnt     <= '0;
            trig_en_r   <= 1'b0;
            trig_ch_r   <= '0;
            trig_lvl_r  <= '0;
            prev_smp    <= '0;
            prev_vld    <= 1'b0;
            wr_idx      <= '0;
            out_valid_r <= 1'b0;
            out_ch_r    <= '0;
            out_idx_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state      <= ST_ARM;
                        busy_r     <= 1'b1;
                        decim_r    <= bus.decim;
                        trig_en_r  <= bus.trig_en;
                        trig_ch_r  <= bus.trig_ch;
                        trig_lvl_r <= bus.trig_level;
                        prev_vld   <= 1'b0;
                        dec_cnt    <= '0;
                        wr_idx     <= '0;
                    end
                end
                ST_ARM: begin
                    if (!trig_en_r) begin
                        state <= ST_CAPTURE;
                    end else if (acc) begin
                        prev_smp <= trig_smp;
                        prev_vld <= 1'b1;
                        if (trig_hit)
                            state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                end
                ST_DRAIN: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        out_ch_r    <= '0;
                        out_idx_r   <= '0;
                    end else if (bus.out_ready) begin
                        if (rd_last) begin
                            out_valid_r <= 1'b0;
                            state       <= ST_IDLE;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                        end else if (out_idx_r == IDX_LAST) begin
                            out_idx_r <= '0;
                            out_ch_r  <= out_ch_r + CHW'(1);
                        end else begin
                            out_idx_r <= out_idx_r + IDXW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Window counting; stalls on smpl_valid low simply leave the counter parked.
            if (take) begin
                if (win_last) begin
                    dec_cnt <= '0;
                    wr_idx  <= wr_idx + IDXW'(1);
                    if (wr_idx == IDX_LAST)
                        state <= ST_DRAIN;
                end else begin
                    dec_cnt <= dec_cnt + DECW'(1);
                end
            end
        end
    end

    assign rd_last = (out_ch_r == CH_LAST) && (out_idx_r == IDX_LAST);

    // Read one point ahead on a transfer so the registered RAM output keeps one beat per cycle.
    always_comb begin
        rd_addr = out_idx_r;
        if (state == ST_DRAIN && !out_valid_r)
            rd_addr = '0;
        else if (out_valid_r && bus.out_ready)
            rd_addr = (out_idx_r == IDX_LAST) ? '0 : out_idx_r + IDXW'(1);
    end

    smpl_buf_ram #(
        .W     (BW),
        .DEPTH (SIZE),
        .AW    (IDXW)
    ) u_buf (
        .clkSmpl (clkSmpl),
        .we      (wr_en),
        .waddr   (wr_idx),
        .wdata   (win_next),
        .raddr   (rd_addr),
        .rdata   (rd_word)
    );

    always_comb begin
        out_sel = '0;
        for (int c = 0; c < CH; c++)
            if (out_ch_r == CHW'(c))
                out_sel = rd_word[c*SN +: SN];
    end

    assign bus.out_data = out_valid_r ? out_sel : '0;

endmodule

// File: doc/smpl_capture_multi.md
SMPL_CAPTURE_MULTI -- requirements
Module: smpl_capture_multi

Interface
REQ-001 Parameter CH, 2, number of sample channels.
REQ-002 Parameter SN, 10, bits per channel sample.
REQ-003 Parameter SIZE, 64, captured points per channel per frame.
REQ-004 Parameter DECW, 8, width of decimation-ratio input.
REQ-005 clkSmpl  in  1  sample clock; reset n_reset, asynchronous, active-low; all logic on clkSmpl.
REQ-006 n_reset  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle pulse arming one capture frame.
REQ-008 busy  out  1  high from accepted start until done.
REQ-009 done  out  1  single-cycle pulse at frame completion.
REQ-010 decim  in  DECW  decimation ratio minus one, sampled on accepted start.
REQ-011 trig_en, trig_ch, trig_level  in  1, $clog2(CH), SN  trigger enable, channel, level; sampled on accepted start.
REQ-012 smpl_valid  in  1; smpl_req  out  1; smpl  in  CH*SN  sample stream, channel 0 in LSBs; sample accepted when smpl_valid && smpl_req.
REQ-013 out_valid  out  1; out_ready  in  1  output handshake; transfer when both high.
REQ-014 out_data, out_ch, out_idx  out  SN, $clog2(CH), $clog2(SIZE)  point value, channel, point index.

Function
REQ-015 States SHALL be Idle, Arm, Capture, Drain; start SHALL be accepted only in Idle and ignored otherwise.
REQ-016 Idle -> Arm on start; Arm -> Capture on trigger (immediately next cycle when trig_en=0); Capture -> Drain when SIZE points stored; Drain -> Idle after the final output transfer.
REQ-017 Trigger SHALL be a rising crossing on trig_ch: previous accepted sample < trig_level and current accepted sample >= trig_level; the triggering sample SHALL be point 0 input.
REQ-018 smpl_req SHALL be high in Arm and Capture, low in Idle and Drain.
REQ-019 In Capture, every decim+1 accepted samples SHALL form one point; decim=0 SHALL store every accepted sample; smpl_valid low SHALL stall counting without loss.
REQ-020 All CH channels of a point SHALL be written in the same cycle to buffer address point index.
REQ-021 Drain SHALL emit CH*SIZE transfers, channel-major (ch0 idx0..SIZE-1, then ch1, ...); buffer read latency one cycle, out_valid rising one cycle after Drain entry.
REQ-022 out_data/out_ch/out_idx SHALL stay stable while out_valid && ~out_ready; out_valid SHALL not drop without a transfer.
REQ-023 Back-to-back transfers SHALL sustain one per cycle while out_ready stays high.
REQ-024 done SHALL pulse the cycle after the final transfer; busy SHALL fall in the same cycle done pulses.
REQ-025 Decimation counter SHALL be DECW bits, clear on Capture entry, wrap at decim without overflow for decim=2^DECW-1.

Reset
REQ-026 Reset SHALL force Idle; busy, done, smpl_req, out_valid, out_data, out_ch, out_idx, all counters to 0; buffer contents undefined.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no done pulse; first start after release SHALL begin a fresh frame.

Configuration
REQ-028 Macro SMPL_PEAK_DETECT_EN defined: each point SHALL store, per channel, the maximum of its decim+1 samples (unsigned compare).
REQ-029 Macro SMPL_PEAK_DETECT_EN undefined: each point SHALL store the first sample of its window; peak comparators SHALL not be instantiated.

Structure
REQ-030 Shared package smpl_pkg SHALL hold the state enum type and index-width helper constants.
REQ-031 Sub-module smpl_buf_ram SHALL implement the simple dual-port CH*SN-wide, SIZE-deep buffer with registered read.

Verification
REQ-032 trig_en=0, decim=0, ramp 0..63 on ch0 -> 128 outputs, ch0 idx i = i, done pulse once, busy falls with done.
REQ-033 trig_en=1, trig_ch=1, level=512, ch1 sine crossing 512 upward at sample 37 -> ch1 idx0 = first value >=512, nothing stored before it.
REQ-034 decim=3, ch0 pattern 1,9,4,2 repeating -> idx values 9 with SMPL_PEAK_DETECT_EN, 1 without.
REQ-035 out_ready toggled randomly in Drain -> no lost/duplicated point, outputs stable while stalled, order channel-major.
REQ-036 smpl_valid duty 30%, decim=255 -> point count correct, no counter overflow, smpl_req low in Drain.
REQ-037 n_reset pulsed at idx 20 of Capture, then start -> no done from aborted frame, new frame fully correct.
